// File: rtl/bp_be_pkg.sv
// Package for the BE issue queue: pre-decoded status payload, RV64IMAFD
// opcode-class constants and the pre-decode function used on the head entry.
package bp_be_pkg;

    localparam int unsigned RegAddrW = 5;

    typedef struct packed {
        logic [RegAddrW-1:0] rs1_addr;
        logic [RegAddrW-1:0] rs2_addr;
        logic [RegAddrW-1:0] rs3_addr;
        logic [RegAddrW-1:0] rd_addr;
        logic                irs1_v;
        logic                irs2_v;
        logic                frs1_v;
        logic                frs2_v;
        logic                frs3_v;
        logic                iwb_v;
        logic                fwb_v;
        logic                mem_v;
        logic                fence_v;
        logic                csr_w_v;
        logic                long_v;
    } bp_be_isq_status_s;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpLoadFp  = 7'b0000111;
    localparam logic [6:0] OpMiscMem = 7'b0001111;
    localparam logic [6:0] OpOpImm   = 7'b0010011;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpOpImm32 = 7'b0011011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpStoreFp = 7'b0100111;
    localparam logic [6:0] OpAmo     = 7'b0101111;
    localparam logic [6:0] OpOp      = 7'b0110011;
    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpOp32    = 7'b0111011;
    localparam logic [6:0] OpMadd    = 7'b1000011;
    localparam logic [6:0] OpMsub    = 7'b1000111;
    localparam logic [6:0] OpNmsub   = 7'b1001011;
    localparam logic [6:0] OpNmadd   = 7'b1001111;
    localparam logic [6:0] OpOpFp    = 7'b1010011;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpSystem  = 7'b1110011;

    // OP-FP funct5 sub-classes, instr[31:27]
    localparam logic [4:0] FpDiv    = 5'b00011;
    localparam logic [4:0] FpSqrt   = 5'b01011;
    localparam logic [4:0] FpCvtFF  = 5'b01000;
    localparam logic [4:0] FpCmp    = 5'b10100;
    localparam logic [4:0] FpCvtIF  = 5'b11000;
    localparam logic [4:0] FpCvtFI  = 5'b11010;
    localparam logic [4:0] FpMvXF   = 5'b11100;
    localparam logic [4:0] FpMvFX   = 5'b11110;

    function automatic bp_be_isq_status_s bp_be_isq_predecode(input logic [31:0] instr);
        bp_be_isq_status_s s;
        s          = '0;
        s.rs1_addr = instr[19:15];
        s.rs2_addr = instr[24:20];
        s.rs3_addr = instr[31:27];
        s.rd_addr  = instr[11:7];
        case (instr[6:0])
            OpLoad:              begin s.irs1_v = 1'b1; s.iwb_v = 1'b1; s.mem_v = 1'b1; end
            OpLoadFp:            begin s.irs1_v = 1'b1; s.fwb_v = 1'b1; s.mem_v = 1'b1; end
            OpStore:             begin s.irs1_v = 1'b1; s.irs2_v = 1'b1; s.mem_v = 1'b1; end
            OpStoreFp:           begin s.irs1_v = 1'b1; s.frs2_v = 1'b1; s.mem_v = 1'b1; end
            OpMiscMem:           s.fence_v = 1'b1;
            OpOpImm, OpOpImm32:  begin s.irs1_v = 1'b1; s.iwb_v = 1'b1; end
            OpAuipc, OpLui, OpJal: s.iwb_v = 1'b1;
            OpJalr:              begin s.irs1_v = 1'b1; s.iwb_v = 1'b1; end
            OpBranch:            begin s.irs1_v = 1'b1; s.irs2_v = 1'b1; end
            OpAmo:               begin s.irs1_v = 1'b1; s.irs2_v = 1'b1; s.iwb_v = 1'b1; s.mem_v = 1'b1; end
            OpOp, OpOp32: begin
                s.irs1_v = 1'b1; s.irs2_v = 1'b1; s.iwb_v = 1'b1;
                // M-extension mul/div is multi-cycle
                s.long_v = (instr[31:25] == 7'b0000001);
            end
            OpMadd, OpMsub, OpNmsub, OpNmadd: begin
                s.frs1_v = 1'b1; s.frs2_v = 1'b1; s.frs3_v = 1'b1;
                s.fwb_v  = 1'b1; s.long_v = 1'b1;
            end
            OpOpFp: begin
                case (instr[31:27])
                    FpCmp:            begin s.frs1_v = 1'b1; s.frs2_v = 1'b1; s.iwb_v = 1'b1; end
                    FpMvXF, FpCvtIF:  begin s.frs1_v = 1'b1; s.iwb_v = 1'b1; end
                    FpCvtFI, FpMvFX:  begin s.irs1_v = 1'b1; s.fwb_v = 1'b1; end
                    FpSqrt:           begin s.frs1_v = 1'b1; s.fwb_v = 1'b1; s.long_v = 1'b1; end
                    FpCvtFF:          begin s.frs1_v = 1'b1; s.fwb_v = 1'b1; end
                    FpDiv:            begin s.frs1_v = 1'b1; s.frs2_v = 1'b1; s.fwb_v = 1'b1; s.long_v = 1'b1; end
                    default:          begin s.frs1_v = 1'b1; s.frs2_v = 1'b1; s.fwb_v = 1'b1; end
                endcase
            end
            OpSystem: begin
                if (instr[14:12] != 3'b000) begin
                    s.iwb_v   = 1'b1;
                    s.irs1_v  = ~instr[14];
                    // CSRRW/I always write; CSRRS/C only with a non-zero source
                    s.csr_w_v = (instr[13:12] == 2'b01) | (instr[19:15] != 5'd0);
                end
            end
            default: s = s;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bp_be_isq_predecode.sv
// Combinational pre-decode of the head instruction into register-use status.
// Ports: v_i (head valid), instr_i (head instruction), status_o (zero when !v_i).
module bp_be_isq_predecode
    import bp_be_pkg::*;
(
    input  logic              v_i,
    input  logic [31:0]       instr_i,
    output bp_be_isq_status_s status_o
);

    always_comb begin
        status_o = '0;
        if (v_i) status_o = bp_be_pkg::bp_be_isq_predecode(instr_i);
    end

endmodule

// File: rtl/bp_be_issue_queue.sv
// Circular issue buffer between the FE queue and the BE hazard detector.
// Keeps dispatched-but-uncommitted entries so the stream can be rolled back.
// Optional macro BP_BE_ISQ_BYPASS_EN: enqueue into an empty queue drives the
// issue outputs in the same cycle.
// Ports: clk_i, reset_n_i (sync, active-low); enq_v_i/enq_pc_i/enq_instr_i,
// enq_ready_o; issue_v_o/issue_pc_o/issue_instr_o, isd_status_o;
// dispatch_v_i, cmt_v_i, roll_v_i, clr_v_i; empty_o.
module bp_be_issue_queue
    import bp_be_pkg::*;
#(
    parameter int unsigned els_p         = 16,
    parameter int unsigned vaddr_width_p = 39,
    parameter int unsigned instr_width_p = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     enq_v_i,
    input  logic [vaddr_width_p-1:0] enq_pc_i,
    input  logic [instr_width_p-1:0] enq_instr_i,
    output logic                     enq_ready_o,
    output logic                     issue_v_o,
    output logic [vaddr_width_p-1:0] issue_pc_o,
    output logic [instr_width_p-1:0] issue_instr_o,
    output bp_be_isq_status_s        isd_status_o,
    input  logic                     dispatch_v_i,
    input  logic                     cmt_v_i,
    input  logic                     roll_v_i,
    input  logic                     clr_v_i,
    output logic                     empty_o
);

    localparam int unsigned IdxW   = $clog2(els_p);
    localparam int unsigned PtrW   = IdxW + 1;
    localparam int unsigned EntryW = vaddr_width_p + instr_width_p;

    logic [PtrW-1:0]   wptr_q, rptr_q, cptr_q;
    logic [PtrW-1:0]   wptr_d, rptr_d, cptr_d, cptr_nxt;
    logic [EntryW-1:0] mem_q [els_p];
    logic [EntryW-1:0] head_entry;
    logic              head_v, enq_ok, disp_ok, cmt_ok;

    // Flags depend on pointer state only
    assign enq_ready_o = (wptr_q - cptr_q) != PtrW'(els_p);
    assign empty_o     = (wptr_q == cptr_q);
    assign head_v      = (rptr_q != wptr_q);
    assign head_entry  = mem_q[rptr_q[IdxW-1:0]];

`ifdef BP_BE_ISQ_BYPASS_EN
    logic byp;
    assign byp       = empty_o & enq_v_i & ~clr_v_i & ~roll_v_i;
    assign issue_v_o = head_v | byp;
    assign {issue_pc_o, issue_instr_o} = byp ? {enq_pc_i, enq_instr_i} : head_entry;
`else
    assign issue_v_o = head_v;
    assign {issue_pc_o, issue_instr_o} = head_entry;
`endif

    assign enq_ok  = enq_v_i & enq_ready_o & ~clr_v_i;
    assign disp_ok = dispatch_v_i & issue_v_o;
    assign cmt_ok  = cmt_v_i & (rptr_q != cptr_q);

    // Pointer next-state: clr > roll > {enq, dispatch, commit}
    always_comb begin
        cptr_nxt = cptr_q + PtrW'(cmt_ok);
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cptr_d   = cptr_nxt;
        if (clr_v_i) begin
            wptr_d = cptr_nxt;
            rptr_d = cptr_nxt;
        end else begin
            wptr_d = wptr_q + PtrW'(enq_ok);
            rptr_d = roll_v_i ? cptr_nxt : rptr_q + PtrW'(disp_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    // Storage: synchronous write, asynchronous read, no reset
    always_ff @(posedge clk_i) begin
        if (enq_ok) mem_q[wptr_q[IdxW-1:0]] <= {enq_pc_i, enq_instr_i};
    end

    bp_be_isq_predecode u_predecode (
        .v_i      (issue_v_o),
        .instr_i  (issue_instr_o),
        .status_o (isd_status_o)
    );

    // Protocol checks on the detector/commit interface
    assert property (@(posedge clk_i) disable iff (!reset_n_i) dispatch_v_i |-> issue_v_o);
    assert property (@(posedge clk_i) disable iff (!reset_n_i) cmt_v_i |-> (rptr_q != cptr_q));

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Directed self-checking bench for bp_be_issue_queue.
module tb_bp_be_issue_queue;
    import bp_be_pkg::*;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic              enq_v_i;
    logic [38:0]       enq_pc_i;
    logic [31:0]       enq_instr_i;
    logic              enq_ready_o;
    logic              issue_v_o;
    logic [38:0]       issue_pc_o;
    logic [31:0]       issue_instr_o;
    bp_be_isq_status_s isd_status_o;
    logic              dispatch_v_i, cmt_v_i, roll_v_i, clr_v_i;
    logic              empty_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] Nop = 32'h0000_0013;

    bp_be_issue_queue dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .enq_v_i(enq_v_i), .enq_pc_i(enq_pc_i), .enq_instr_i(enq_instr_i),
        .enq_ready_o(enq_ready_o),
        .issue_v_o(issue_v_o), .issue_pc_o(issue_pc_o), .issue_instr_o(issue_instr_o),
        .isd_status_o(isd_status_o),
        .dispatch_v_i(dispatch_v_i), .cmt_v_i(cmt_v_i), .roll_v_i(roll_v_i), .clr_v_i(clr_v_i),
        .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        enq_v_i = 1'b0; dispatch_v_i = 1'b0; cmt_v_i = 1'b0;
        roll_v_i = 1'b0; clr_v_i = 1'b0;
    endtask

    task automatic enq(input logic [38:0] pc, input logic [31:0] instr);
        enq_v_i = 1'b1; enq_pc_i = pc; enq_instr_i = instr;
        tick();
        enq_v_i = 1'b0;
    endtask

    task automatic commit_n(input int n);
        cmt_v_i = 1'b1;
        repeat (n) tick();
        cmt_v_i = 1'b0;
    endtask

    initial begin
        logic [31:0] fmadd;
        int          issued, inflight, sent;
        logic        rdy, did_disp, did_cmt;

        reset_n_i = 1'b0; enq_pc_i = '0; enq_instr_i = '0;
        idle_inputs();
        repeat (2) tick();
        check("rst_ready",  64'(enq_ready_o), 64'd1);
        check("rst_issue_v", 64'(issue_v_o), 64'd0);
        check("rst_empty",  64'(empty_o), 64'd1);
        check("rst_status", 64'(isd_status_o), 64'd0);
        reset_n_i = 1'b1;
        tick();

        // 1. fill to capacity
        for (int i = 0; i < 16; i++) enq(39'('h1000 + 4 * i), Nop);
        enq_v_i = 1'b1; enq_pc_i = 39'h dead; #1;
        check("full_ready",   64'(enq_ready_o), 64'd0);
        check("full_head_pc", 64'(issue_pc_o), 64'h1000);
        check("full_empty",   64'(empty_o), 64'd0);
        check("full_issue_v", 64'(issue_v_o), 64'd1);
        tick(); enq_v_i = 1'b0;
        dispatch_v_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("full_order", 64'(issue_pc_o), 64'('h1000 + 4 * i));
            tick();
        end
        dispatch_v_i = 1'b0; #1;
        check("inflight_ready", 64'(enq_ready_o), 64'd0);
        check("inflight_issue_v", 64'(issue_v_o), 64'd0);
        // full + commit + enq: enqueue not taken
        cmt_v_i = 1'b1; enq_v_i = 1'b1; enq_pc_i = 39'h beef;
        tick(); idle_inputs(); #1;
        check("fullcmt_issue_v", 64'(issue_v_o), 64'd0);
        check("fullcmt_ready",   64'(enq_ready_o), 64'd1);
        commit_n(15);
        check("drain_empty", 64'(empty_o), 64'd1);

        // 2. stream 20 entries with dispatch+commit, wrapping pointers
        issued = 0; inflight = 0; sent = 0;
        for (int cyc = 0; cyc < 80 && issued < 20; cyc++) begin
            enq_v_i = (sent < 20); enq_pc_i = 39'('h2000 + 4 * sent); enq_instr_i = Nop;
            cmt_v_i = (inflight > 0);
            #1;
            rdy = enq_ready_o;
            did_disp = issue_v_o; did_cmt = cmt_v_i;
            dispatch_v_i = issue_v_o;
            if (issue_v_o) begin
                check("stream_pc", 64'(issue_pc_o), 64'('h2000 + 4 * issued));
                issued++;
            end
            tick();
            if (enq_v_i && rdy) sent++;
            inflight = inflight + int'(did_disp) - int'(did_cmt);
            idle_inputs();
        end
        check("stream_count", 64'(issued), 64'd20);
        if (inflight > 0) commit_n(inflight);
        check("stream_empty", 64'(empty_o), 64'd1);

        // 3. roll replays from the commit pointer
        enq(39'h3000, Nop); enq(39'h3004, Nop); enq(39'h3008, Nop);
        dispatch_v_i = 1'b1; tick(); tick(); dispatch_v_i = 1'b0;
        commit_n(1);
        roll_v_i = 1'b1; tick(); roll_v_i = 1'b0;
        check("roll_v",  64'(issue_v_o), 64'd1);
        check("roll_pc", 64'(issue_pc_o), 64'h3004);
        dispatch_v_i = 1'b1; tick();
        check("roll_next_pc", 64'(issue_pc_o), 64'h3008);
        tick(); dispatch_v_i = 1'b0;
        commit_n(2);
        check("roll_empty", 64'(empty_o), 64'd1);

        // 4. clr with same-cycle commit and enqueue
        enq(39'h4000, Nop); enq(39'h4004, Nop); enq(39'h4008, Nop);
        dispatch_v_i = 1'b1; repeat (3) tick(); dispatch_v_i = 1'b0;
        clr_v_i = 1'b1; cmt_v_i = 1'b1; enq_v_i = 1'b1; enq_pc_i = 39'h9999;
        tick(); idle_inputs();
        check("clr_empty",   64'(empty_o), 64'd1);
        check("clr_issue_v", 64'(issue_v_o), 64'd0);
        check("clr_ready",   64'(enq_ready_o), 64'd1);
        tick();
        check("clr_drop", 64'(issue_v_o), 64'd0);

        // 5. pre-decode of FMADD.D f1,f2,f3,f4 and ADDI x0
        fmadd = {5'd4, 2'b01, 5'd3, 5'd2, 3'b000, 5'd1, 7'b1000011};
        enq(39'h5000, fmadd);
        check("fma_frs1", 64'(isd_status_o.frs1_v), 64'd1);
        check("fma_frs2", 64'(isd_status_o.frs2_v), 64'd1);
        check("fma_frs3", 64'(isd_status_o.frs3_v), 64'd1);
        check("fma_fwb",  64'(isd_status_o.fwb_v), 64'd1);
        check("fma_rs3",  64'(isd_status_o.rs3_addr), 64'd4);
        check("fma_iwb",  64'(isd_status_o.iwb_v), 64'd0);
        dispatch_v_i = 1'b1; tick(); dispatch_v_i = 1'b0;
        check("idle_status", 64'(isd_status_o), 64'd0);
        enq(39'h5004, 32'h0000_0013);
        check("addi_iwb",  64'(isd_status_o.iwb_v), 64'd1);
        check("addi_rd",   64'(isd_status_o.rd_addr), 64'd0);
        check("addi_irs1", 64'(isd_status_o.irs1_v), 64'd1);
        check("addi_fwb",  64'(isd_status_o.fwb_v), 64'd0);
        dispatch_v_i = 1'b1; tick(); dispatch_v_i = 1'b0;
        commit_n(2);
        check("pd_empty", 64'(empty_o), 64'd1);

        // 6. enqueue-to-issue latency on an empty queue
`ifdef BP_BE_ISQ_BYPASS_EN
        enq_v_i = 1'b1; enq_pc_i = 39'h6000; enq_instr_i = Nop; #1;
        check("byp_v",  64'(issue_v_o), 64'd1);
        check("byp_pc", 64'(issue_pc_o), 64'h6000);
        dispatch_v_i = 1'b1;
        tick(); idle_inputs();
        check("byp_empty",   64'(empty_o), 64'd0);
        check("byp_issue_v", 64'(issue_v_o), 64'd0);
        commit_n(1);
`else
        enq_v_i = 1'b1; enq_pc_i = 39'h6000; enq_instr_i = Nop; #1;
        check("lat_same_v", 64'(issue_v_o), 64'd0);
        tick(); idle_inputs();
        check("lat_next_v",  64'(issue_v_o), 64'd1);
        check("lat_next_pc", 64'(issue_pc_o), 64'h6000);
        dispatch_v_i = 1'b1; tick(); dispatch_v_i = 1'b0;
        commit_n(1);
`endif
        check("end_empty", 64'(empty_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
